// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: opcodes,
// ALUOp codes, datapath select values and the control FSM state type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    // State following DECODE for a given opcode; unknown opcodes trap.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXECUTE;
            OP_BEQ:       nxt = S_BRANCH;
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mips_retire_counter.sv
// Free-running retired-instruction counter; wraps silently at full scale.
module mips_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mips_main_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with memory-ready stalls and a retired-instruction count.
module mips_main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    state_t state_reg;
    logic   retire_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            case (state_reg)
                S_FETCH:   if (mem_ready) state_reg <= S_DECODE;
                S_DECODE:  state_reg <= decode_next(opcode);
                S_MEMADR:  state_reg <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state_reg <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state_reg <= S_FETCH;
                S_EXECUTE: state_reg <= S_ALUWB;
                S_ADDIEX:  state_reg <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_ILLEGAL:
                           state_reg <= S_FETCH;
                default:   state_reg <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = PCSRC_ALU;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RT;
        ALUOp      = ALUOP_ADD;
        RegWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        illegal_op = 1'b0;
        retire_en  = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH2;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                retire_en = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                MemWrite  = mem_ready;
                retire_en = mem_ready;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                retire_en = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALUOP_SUB;
                PCSrc     = PCSRC_ALUOUT;
                Branch    = 1'b1;
                retire_en = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                retire_en = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = PCSRC_JUMP;
                PCWrite   = 1'b1;
                retire_en = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
        // FETCH strobes follow mem_ready, so they must be squashed while held in reset.
        if (!rst_n) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
            retire_en  = 1'b0;
        end
    end

    mips_retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (retire_en),
        .count (retired)
    );

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Scoreboard bench for the MIPS main control FSM: the driver queues the
// hand-derived control word per cycle, a negedge monitor pops and compares.
module tb_mips_main_control_fsm;

    localparam int CNT_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BAD   = 6'b111111;

    // Field order: IorD MemWrite IRWrite PCWrite Branch PCSrc[2] ALUSrcA
    //              ALUSrcB[2] ALUOp[2] RegWrite MemtoReg RegDst illegal_op
    localparam logic [15:0] V_FETCH       = 16'b0_0_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [15:0] V_FETCH_STALL = 16'b0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [15:0] V_DECODE      = 16'b0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [15:0] V_MEMADR      = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [15:0] V_MEMRD       = 16'b1_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] V_MEMWB       = 16'b0_0_0_0_0_00_0_00_00_1_1_0_0;
    localparam logic [15:0] V_MEMWR_STALL = 16'b1_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] V_MEMWR       = 16'b1_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [15:0] V_EXECUTE     = 16'b0_0_0_0_0_00_1_00_10_0_0_0_0;
    localparam logic [15:0] V_ALUWB       = 16'b0_0_0_0_0_00_0_00_00_1_0_1_0;
    localparam logic [15:0] V_BRANCH      = 16'b0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [15:0] V_ADDIEX      = 16'b0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [15:0] V_ADDIWB      = 16'b0_0_0_0_0_00_0_00_00_1_0_0_0;
    localparam logic [15:0] V_JUMP        = 16'b0_0_0_1_0_10_0_00_00_0_0_0_0;
    localparam logic [15:0] V_ILLEGAL     = 16'b0_0_0_0_0_00_0_00_00_0_0_0_1;

    typedef struct packed {
        logic [15:0]      ctl;
        logic [CNT_W-1:0] ret;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0]       PCSrc;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp;
    logic             RegWrite, MemtoReg, RegDst, illegal_op;
    logic [CNT_W-1:0] retired;

    exp_t             exp_q[$];
    string            lbl_q[$];
    logic [CNT_W-1:0] ret;
    int               n_vec = 0;
    int               n_miss = 0;

    mips_main_control_fsm #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .PCSrc      (PCSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Monitor: one expected control word per clock cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            string       l;
            logic [15:0] act;
            e   = exp_q.pop_front();
            l   = lbl_q.pop_front();
            act = {IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA,
                   ALUSrcB, ALUOp, RegWrite, MemtoReg, RegDst, illegal_op};
            n_vec++;
            if (act !== e.ctl || retired !== e.ret) begin
                n_miss++;
                $display("FAIL %s: got ctl=%b retired=%0d, want ctl=%b retired=%0d",
                         l, act, retired, e.ctl, e.ret);
            end else begin
                $display("vec %0d %s: ctl=%b retired=%0d ok", n_vec, l, act, retired);
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic mr, input logic [15:0] c,
                       input string lbl);
        opcode    = op;
        mem_ready = mr;
        exp_q.push_back('{ctl: c, ret: ret});
        lbl_q.push_back(lbl);
        @(posedge clk);
        #1;
    endtask

    task automatic run_rtype();
        cyc(OP_RTYPE, 1'b1, V_FETCH,   "r.fetch");
        cyc(OP_RTYPE, 1'b0, V_DECODE,  "r.decode");
        cyc(OP_RTYPE, 1'b1, V_EXECUTE, "r.execute");
        cyc(OP_RTYPE, 1'b0, V_ALUWB,   "r.aluwb");
        ret = ret + 1'b1;
    endtask

    task automatic run_j();
        cyc(OP_J, 1'b1, V_FETCH,  "j.fetch");
        cyc(OP_J, 1'b0, V_DECODE, "j.decode");
        cyc(OP_J, 1'b1, V_JUMP,   "j.jump");
        ret = ret + 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = OP_RTYPE;
        mem_ready = 1'b1;
        ret       = '0;
        @(posedge clk);
        #1;
        // Held in reset with mem_ready high: FETCH selects, no strobes.
        cyc(OP_RTYPE, 1'b1, V_FETCH_STALL, "reset.hold");
        cyc(OP_RTYPE, 1'b1, V_FETCH_STALL, "reset.hold");
        rst_n = 1'b1;

        run_rtype();

        // lw with three memory stalls in MEMRD: 8 cycles total
        cyc(OP_LW, 1'b1, V_FETCH,  "lw.fetch");
        cyc(OP_LW, 1'b0, V_DECODE, "lw.decode");
        cyc(OP_LW, 1'b1, V_MEMADR, "lw.memadr");
        cyc(OP_LW, 1'b0, V_MEMRD,  "lw.memrd.stall");
        cyc(OP_LW, 1'b0, V_MEMRD,  "lw.memrd.stall");
        cyc(OP_LW, 1'b0, V_MEMRD,  "lw.memrd.stall");
        cyc(OP_LW, 1'b1, V_MEMRD,  "lw.memrd.done");
        cyc(OP_LW, 1'b0, V_MEMWB,  "lw.memwb");
        ret = ret + 1'b1;

        // sw with two stalls in MEMWR: MemWrite only on the ready cycle
        cyc(OP_SW, 1'b1, V_FETCH,       "sw.fetch");
        cyc(OP_SW, 1'b1, V_DECODE,      "sw.decode");
        cyc(OP_SW, 1'b0, V_MEMADR,      "sw.memadr");
        cyc(OP_SW, 1'b0, V_MEMWR_STALL, "sw.memwr.stall");
        cyc(OP_SW, 1'b0, V_MEMWR_STALL, "sw.memwr.stall");
        cyc(OP_SW, 1'b1, V_MEMWR,       "sw.memwr.done");
        ret = ret + 1'b1;

        cyc(OP_BEQ, 1'b1, V_FETCH,  "beq.fetch");
        cyc(OP_BEQ, 1'b1, V_DECODE, "beq.decode");
        cyc(OP_BEQ, 1'b0, V_BRANCH, "beq.branch");
        ret = ret + 1'b1;
        run_j();

        // Unknown opcode: one-cycle illegal_op, no retire
        cyc(OP_BAD, 1'b1, V_FETCH,   "ill.fetch");
        cyc(OP_BAD, 1'b1, V_DECODE,  "ill.decode");
        cyc(OP_BAD, 1'b1, V_ILLEGAL, "ill.trap");
        cyc(OP_BAD, 1'b0, V_FETCH_STALL, "ill.back.fetch");

        // Fill the 4-bit counter to 15, then addi makes it wrap to 0
        for (int i = 0; i < 10; i++) run_j();
        cyc(OP_ADDI, 1'b0, V_FETCH_STALL, "addi.fetch.stall");
        cyc(OP_ADDI, 1'b1, V_FETCH,       "addi.fetch");
        cyc(OP_ADDI, 1'b0, V_DECODE,      "addi.decode");
        cyc(OP_ADDI, 1'b1, V_ADDIEX,      "addi.ex");
        cyc(OP_ADDI, 1'b1, V_ADDIWB,      "addi.wb.at15");
        ret = ret + 1'b1;
        cyc(OP_ADDI, 1'b0, V_FETCH_STALL, "wrap.zero");

        run_j();

        // Reset during MEMADR of a sw: abort, no MemWrite, counter cleared
        cyc(OP_SW, 1'b1, V_FETCH,  "swrst.fetch");
        cyc(OP_SW, 1'b1, V_DECODE, "swrst.decode");
        rst_n = 1'b0;
        ret   = '0;
        cyc(OP_SW, 1'b1, V_FETCH_STALL, "swrst.in.reset");
        cyc(OP_SW, 1'b1, V_FETCH_STALL, "swrst.in.reset");
        rst_n = 1'b1;
        cyc(OP_SW, 1'b0, V_FETCH_STALL, "swrst.after");
        run_rtype();
        cyc(OP_RTYPE, 1'b0, V_FETCH_STALL, "final.idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
